// File: rtl/manchester_pkg.sv
// Shared types and threshold helpers for the Manchester symbol decision stage.
// Defaults of the threshold functions correspond to 16 samples per bit.
package manchester_pkg;

  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    FADE   = 2'd2
  } state_t;

  // Highest in-phase mismatch sum still decided as a 1.
  function automatic int low_th(input int n_samp = 16);
    return n_samp / 4;
  endfunction

  // Lowest in-phase mismatch sum decided as a 0.
  function automatic int high_th(input int n_samp = 16);
    return n_samp - n_samp / 4;
  endfunction

  function automatic int mid_th(input int n_samp = 16);
    return n_samp / 2;
  endfunction

endpackage

// File: rtl/mdec_classify.sv
// Combinational symbol classifier: in-phase sum gives bit/erasure,
// quadrature sum gives the phase-adjust direction for good symbols.
module mdec_classify #(
  parameter int N_SAMP = 16,
  parameter int SUM_W  = manchester_pkg::SUM_W,
  parameter int Q_TH   = 2
) (
  input  logic [SUM_W-1:0] isum,
  input  logic [SUM_W-1:0] qsum,
  output logic             good,
  output logic             bit_val,
  output logic             adv,
  output logic             ret
);
  import manchester_pkg::*;

  localparam int L = low_th(N_SAMP);
  localparam int H = high_th(N_SAMP);
  localparam int M = mid_th(N_SAMP);

  logic q_hi;
  logic q_lo;

  always_comb begin
    good    = 1'b0;
    bit_val = 1'b0;
    adv     = 1'b0;
    ret     = 1'b0;
    q_hi    = int'(qsum) > (M + Q_TH);
    q_lo    = int'(qsum) < (M - Q_TH);
    if (int'(isum) <= L) begin
      good    = 1'b1;
      bit_val = 1'b1;
    end else if (int'(isum) >= H) begin
      good    = 1'b1;
    end
    // A 0 symbol has the inverted half-bit order, so the correction flips.
    if (good) begin
      adv = bit_val ? q_hi : q_lo;
      ret = bit_val ? q_lo : q_hi;
    end
  end

endmodule

// File: rtl/manchester_decide.sv
// Symbol decision and lock tracking: registers decided bits, phase-adjust
// pulses and lock state once per bit period; clears the convolution sums.
module manchester_decide #(
  parameter int N_SAMP = 16,
  parameter int SUM_W  = manchester_pkg::SUM_W,
  parameter int Q_TH   = 2,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sym_end,
  input  logic [SUM_W-1:0] isum,
  input  logic [SUM_W-1:0] qsum,
  output logic             conv_clr,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             adj_adv,
  output logic             adj_ret,
  output logic             locked,
  output logic [7:0]       erase_cnt
);
  import manchester_pkg::*;

  localparam int CNT_W = $clog2(LOCK_N + 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] good_cnt_reg, good_cnt_next;
  logic [7:0]       erase_cnt_reg, erase_cnt_next;
  logic             bit_out_reg, bit_out_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             adv_reg, adv_next;
  logic             ret_reg, ret_next;

  logic sym_evt;
  logic c_good, c_bit, c_adv, c_ret;

  assign sym_evt  = enable & sym_end;
  assign conv_clr = reset | sym_evt;

  mdec_classify #(
    .N_SAMP (N_SAMP),
    .SUM_W  (SUM_W),
    .Q_TH   (Q_TH)
  ) u_classify (
    .isum    (isum),
    .qsum    (qsum),
    .good    (c_good),
    .bit_val (c_bit),
    .adv     (c_adv),
    .ret     (c_ret)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HUNT;
      good_cnt_reg  <= '0;
      erase_cnt_reg <= '0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      adv_reg       <= 1'b0;
      ret_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      good_cnt_reg  <= good_cnt_next;
      erase_cnt_reg <= erase_cnt_next;
      bit_out_reg   <= bit_out_next;
      bit_valid_reg <= bit_valid_next;
      adv_reg       <= adv_next;
      ret_reg       <= ret_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    erase_cnt_next = erase_cnt_reg;
    bit_out_next   = bit_out_reg;
    bit_valid_next = 1'b0;
    adv_next       = 1'b0;
    ret_next       = 1'b0;
    if (sym_evt) begin
      // Adjusts run in every state so the counter can pull in while hunting.
      adv_next = c_adv;
      ret_next = c_ret;
      if (!c_good && erase_cnt_reg != 8'hFF)
        erase_cnt_next = erase_cnt_reg + 8'd1;
      case (state_reg)
        HUNT: begin
          if (!c_good) begin
            good_cnt_next = '0;
          end else if (good_cnt_reg == CNT_W'(LOCK_N - 1)) begin
            state_next    = LOCKED;
            good_cnt_next = '0;
          end else begin
            good_cnt_next = good_cnt_reg + 1'b1;
          end
        end
        LOCKED: begin
          if (c_good) begin
            bit_valid_next = 1'b1;
            bit_out_next   = c_bit;
          end else begin
            state_next = FADE;
          end
        end
        FADE: begin
          if (c_good) begin
            state_next     = LOCKED;
            bit_valid_next = 1'b1;
            bit_out_next   = c_bit;
          end else begin
            state_next    = HUNT;
            good_cnt_next = '0;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign adj_adv   = adv_reg;
  assign adj_ret   = ret_reg;
  assign locked    = (state_reg == LOCKED);
  assign erase_cnt = erase_cnt_reg;

endmodule
